// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if -- bundles the serial-side and read-side signals of
// serial_word_rx.
//
// Parameter
//   WIDTH     received word width in bits (2..16)
// Signals
//   en        bit strobe; sin/start/dir are only looked at when en=1
//   sin       serial data bit
//   start     first bit of a frame (when en=1)
//   dir       bit order, 0 = MSB-first, 1 = LSB-first (taken from start bit)
//   rd_ready  consumer accepts q
//   clr_ovr   synchronous clear of the overrun flag
//   q         last completed word
//   q_valid   q holds an unconsumed word
//   busy      a frame is being received
//   overrun   sticky: a completed word was dropped
//   bit_cnt   bits captured so far in the current frame
//   dbg_state raw FSM state (0 = IDLE, 1 = RECV)
//
// Read handshake: a word moves to the consumer on every rising edge where
// q_valid=1 and rd_ready=1. q_valid never drops without that transfer
// (or a reset), and rd_ready while q_valid=0 does nothing.
interface serial_word_rx_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             sin;
  logic             start;
  logic             dir;
  logic             rd_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic             overrun;
  logic [4:0]       bit_cnt;
  logic             dbg_state;

  modport master (
    output en, sin, start, dir, rd_ready, clr_ovr,
    input  q, q_valid, busy, overrun, bit_cnt, dbg_state
  );

  modport slave (
    input  en, sin, start, dir, rd_ready, clr_ovr,
    output q, q_valid, busy, overrun, bit_cnt, dbg_state
  );
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx -- deserialises WIDTH-bit frames from a strobed serial
// input into a single-entry output register with a valid/ready read side.
//
// Ports
//   clk    clock, all state updates on its rising edge
//   clr_n  asynchronous active-low reset
//   bus    serial_word_rx_if.slave (see the interface for signal meanings)
//
// A frame begins with a start-marked bit (en=1, start=1); every later bit
// with en=1 shifts in. When the WIDTH-th bit arrives the word completes on
// that same edge and the FSM drops back to IDLE. A start bit seen in RECV
// silently restarts the frame.
module serial_word_rx #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  serial_word_rx_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;
  logic             ovr_q, ovr_d;
  logic             done;
  logic             load;
  logic             ovr_ev;

  // Frame FSM and shift register.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done    = 1'b0;
    if (bus.en) begin
      if (bus.start) begin
        // New frame from either state: earlier partial bits are cleared so
        // nothing from an aborted frame can leak into this one.
        dir_d   = bus.dir;
        sr_d    = bus.dir ? {bus.sin, {(WIDTH-1){1'b0}}}
                          : {{(WIDTH-1){1'b0}}, bus.sin};
        cnt_d   = 5'd1;
        state_d = RECV;
      end else if (state_q == RECV) begin
        sr_d = dir_q ? {bus.sin, sr_q[WIDTH-1:1]}
                     : {sr_q[WIDTH-2:0], bus.sin};
        if (cnt_q == 5'(WIDTH-1)) begin
          done    = 1'b1;
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    end
  end

  // Output register: a completed word loads when the slot is free or being
  // drained on the same edge; otherwise it is dropped and flagged.
  always_comb begin
    load   = done && (!qv_q || bus.rd_ready);
    ovr_ev = done && qv_q && !bus.rd_ready;
    q_d    = load ? sr_d : q_q;
    if (load) begin
      qv_d = 1'b1;
    end else if (qv_q && bus.rd_ready) begin
      qv_d = 1'b0;
    end else begin
      qv_d = qv_q;
    end
    // A drop on the same edge as clr_ovr wins, so no event is ever lost.
    if (ovr_ev) begin
      ovr_d = 1'b1;
    end else if (bus.clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= 5'd0;
      dir_q   <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.q_valid   = qv_q;
  assign bus.busy      = (state_q == RECV);
  assign bus.overrun   = ovr_q;
  assign bus.bit_cnt   = cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx -- self-checking bench for serial_word_rx (WIDTH=4).
// A frame-level model (list of received bits, pending-word queue) runs in
// parallel with the DUT; a compare process checks every output on each
// falling edge, and directed scenarios add literal expectations.
module tb_serial_word_rx;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  serial_word_rx_if #(.WIDTH(W)) bus ();

  serial_word_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q     = '0;
  bit           m_ovr   = 1'b0;
  bit           m_active = 1'b0;
  bit           m_dir   = 1'b0;
  bit           m_bits[$];
  logic [W-1:0] exp_q[$];          // pending (unconsumed) word, size 0 or 1
  logic [W-1:0] m_word;
  bit           m_done;
  bit           m_ovr_ev;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_q      = '0;
      m_ovr    = 1'b0;
      m_active = 1'b0;
      m_dir    = 1'b0;
      m_bits.delete();
      exp_q.delete();
    end else begin
      m_done   = 1'b0;
      m_ovr_ev = 1'b0;
      m_word   = '0;
      if (bus.en) begin
        if (bus.start) begin
          m_bits.delete();
          m_bits.push_back(bus.sin);
          m_dir    = bus.dir;
          m_active = 1'b1;
        end else if (m_active) begin
          m_bits.push_back(bus.sin);
        end
      end
      if (m_active && m_bits.size() == W) begin
        // First received bit lands in the MSB (dir=0) or the LSB (dir=1).
        for (int i = 0; i < W; i++) begin
          if (m_bits[i]) begin
            if (m_dir) m_word = m_word | (W'(1) << i);
            else       m_word = m_word | (W'(1) << (W - 1 - i));
          end
        end
        m_done   = 1'b1;
        m_active = 1'b0;
        m_bits.delete();
      end
      if (m_done) begin
        if (exp_q.size() == 0 || bus.rd_ready) begin
          exp_q.delete();
          exp_q.push_back(m_word);
          m_q = m_word;
        end else begin
          m_ovr_ev = 1'b1;
        end
      end else if (exp_q.size() != 0 && bus.rd_ready) begin
        void'(exp_q.pop_front());
      end
      if (m_ovr_ev)         m_ovr = 1'b1;
      else if (bus.clr_ovr) m_ovr = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q",         32'(bus.q),         32'(m_q));
      chk("q_valid",   32'(bus.q_valid),   32'(exp_q.size() != 0));
      chk("overrun",   32'(bus.overrun),   32'(m_ovr));
      chk("busy",      32'(bus.busy),      32'(m_active));
      chk("bit_cnt",   32'(bus.bit_cnt),   m_active ? 32'(m_bits.size()) : 32'd0);
      chk("dbg_state", 32'(bus.dbg_state), 32'(m_active));
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input bit e, input bit s, input bit d, input bit di,
                      input bit rdy, input bit co);
    bus.en = e; bus.start = s; bus.sin = d; bus.dir = di;
    bus.rd_ready = rdy; bus.clr_ovr = co;
    @(posedge clk); #2;
    bus.en = 1'b0; bus.start = 1'b0; bus.rd_ready = 1'b0; bus.clr_ovr = 1'b0;
  endtask

  // bits[W-1] is sent first.
  task automatic send_frame(input logic [W-1:0] bits, input bit di,
                            input bit rdy_last, input bit co_last);
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, bits[W-1-i], di,
           (i == W-1) ? rdy_last : 1'b0, (i == W-1) ? co_last : 1'b0);
    end
  endtask

  task automatic consume();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q"},       32'(bus.q),       32'd0);
    chk({tag, "_q_valid"}, 32'(bus.q_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_bit_cnt"}, 32'(bus.bit_cnt), 32'd0);
  endtask

  initial begin
    bus.en = 1'b0; bus.start = 1'b0; bus.sin = 1'b0; bus.dir = 1'b0;
    bus.rd_ready = 1'b0; bus.clr_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    clr_n  = 1'b1;
    chk_on = 1'b1;

    // MSB-first 1,0,1,1
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
    chk("msb_q", 32'(bus.q), 32'hB);
    chk("msb_q_valid", 32'(bus.q_valid), 32'd1);
    chk("msb_busy", 32'(bus.busy), 32'd0);
    consume();
    chk("consume_q_valid", 32'(bus.q_valid), 32'd0);
    chk("consume_q_kept", 32'(bus.q), 32'hB);

    // LSB-first 1,0,1,1 with en gaps
    step(1, 1, 1, 1, 0, 0); step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0); step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0); step(0, 0, 0, 1, 0, 0);
    chk("lsb_mid_busy", 32'(bus.busy), 32'd1);
    chk("lsb_mid_cnt", 32'(bus.bit_cnt), 32'd3);
    chk("lsb_mid_q_valid", 32'(bus.q_valid), 32'd0);
    step(1, 0, 1, 1, 0, 0);
    chk("lsb_q", 32'(bus.q), 32'hD);
    chk("lsb_q_valid", 32'(bus.q_valid), 32'd1);
    consume();

    // Overrun: A kept, B dropped, then clear
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
    chk("ovr_q", 32'(bus.q), 32'hB);
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);
    chk("ovr_still_valid", 32'(bus.q_valid), 32'd1);

    // Drain on the completion edge replaces the word
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
    chk("swap_q", 32'(bus.q), 32'h6);
    chk("swap_q_valid", 32'(bus.q_valid), 32'd1);
    chk("swap_overrun", 32'(bus.overrun), 32'd0);

    // Overrun wins over a simultaneous clr_ovr
    send_frame(4'b1001, 1'b0, 1'b0, 1'b1);
    chk("prio_overrun", 32'(bus.overrun), 32'd1);
    chk("prio_q", 32'(bus.q), 32'h6);
    step(0, 0, 0, 0, 0, 1);
    consume();

    // Abort after two bits, restart with 0,0,0,1
    step(1, 1, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
    send_frame(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("abort_q", 32'(bus.q), 32'h1);
    chk("abort_overrun", 32'(bus.overrun), 32'd0);
    consume();

    // Reset mid-frame
    step(1, 1, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    clr_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #2;
    clr_n = 1'b1;
    step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
    chk("no_start_busy", 32'(bus.busy), 32'd0);
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    chk("post_reset_q", 32'(bus.q), 32'hD);
    chk("post_reset_q_valid", 32'(bus.q_valid), 32'd1);
    consume();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) clr_n = 1'b0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      clr_n = 1'b1;
    end

    repeat (2) step(0, 0, 0, 0, 0, 0);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the received word width in bits (legal 2..16).
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port clr_n, input, 1: asynchronous, active-low reset.
REQ-004 Port en, input, 1: bit strobe; sin and start SHALL be sampled only on edges where en=1.
REQ-005 Port sin, input, 1: serial data bit.
REQ-006 Port start, input, 1: marks the first bit of a frame when sampled with en=1.
REQ-007 Port dir, input, 1: bit order; 0 = MSB-first, 1 = LSB-first; sampled on the start bit only.
REQ-008 Port rd_ready, input, 1: consumer accepts q on an edge where q_valid=1 and rd_ready=1.
REQ-009 Port clr_ovr, input, 1: synchronous clear of overrun.
REQ-010 Port q, output, WIDTH: last completed word, registered.
REQ-011 Port q_valid, output, 1: q holds an unconsumed word.
REQ-012 Port busy, output, 1: high while in RECV.
REQ-013 Port overrun, output, 1: sticky flag, a completed word was dropped.
REQ-014 Port bit_cnt, output, 5: number of bits captured in the current frame.

Function
REQ-015 The FSM SHALL have two states: IDLE and RECV.
REQ-016 IDLE, en=1 and start=1: capture sin as bit 0, latch dir, set bit_cnt=1, go to RECV (for WIDTH=1-style completion, see REQ-019).
REQ-017 IDLE, en=0 or start=0: hold; sin ignored.
REQ-018 RECV, en=1, start=0: capture sin and increment bit_cnt; en=0 holds all state.
REQ-019 When the captured bit makes bit_cnt equal WIDTH, the block SHALL complete the word, set bit_cnt=0, and return to IDLE on that same edge.
REQ-020 RECV, en=1, start=1: abort the current frame without any flag, discard partial bits, treat sin as bit 0 of a new frame, and re-latch dir.
REQ-021 MSB-first: shift register SHALL update as {sr[WIDTH-2:0], sin}, so the first bit ends in q[WIDTH-1].
REQ-022 LSB-first: shift register SHALL update as {sin, sr[WIDTH-1:1]}, so the first bit ends in q[0].
REQ-023 Completion with q_valid=0: load q with the full word and set q_valid=1; visible in the cycle after the edge that sampled the last bit.
REQ-024 Completion with q_valid=1 and rd_ready=1 on the same edge: load the new word and keep q_valid=1; overrun unchanged.
REQ-025 Completion with q_valid=1 and rd_ready=0: keep old q, drop the new word, set overrun=1.
REQ-026 q_valid=1, rd_ready=1, no completion: clear q_valid; q retains its value.
REQ-027 rd_ready with q_valid=0 SHALL have no effect.
REQ-028 clr_ovr=1 SHALL clear overrun, except that a simultaneous overrun event takes priority and leaves overrun=1.
REQ-029 busy SHALL equal (state==RECV); bit_cnt SHALL never exceed WIDTH-1 when observed.

Reset
REQ-030 clr_n=0 SHALL immediately force state=IDLE, sr=0, q=0, q_valid=0, overrun=0, bit_cnt=0, busy=0, and latched dir=0.
REQ-031 clr_n deassertion mid-frame SHALL leave no partial-frame residue; the next frame requires start.
REQ-032 No output SHALL be X after reset.

Verification (WIDTH=4)
REQ-033 dir=0, bits 1,0,1,1 with en=1 every cycle, start on the first bit -> q=4'b1011, q_valid=1 one cycle after the 4th edge, busy low.
REQ-034 dir=1, same bits -> q=4'b1101; en toggled 1,0,1,0 between bits -> same q, completion delayed accordingly.
REQ-035 Frame A=1011 completes, rd_ready=0, frame B=0110 completes -> q stays 1011, overrun=1; clr_ovr=1 -> overrun=0.
REQ-036 rd_ready=1 on B's completion edge while A is valid -> q=0110, q_valid=1, overrun=0.
REQ-037 Two bits received, then start=1 with bits 0,0,0,1 -> q=4'b0001, no flag; separately, clr_n pulsed after two bits -> all outputs 0, and the next full frame decodes correctly.
